hp_event_arbiter: RTL
=====================

// Module: hp_event_arbiter
// PURPOSE
//  Sequencer/arbiter owning the player HP register in the game datapath.
//  Takes damage from the pixel collision code, damage from the hazard logic
//  and heal events from pickup logic. Serialises them into one HP update per
//  cycle, enforces an invulnerability window after each hit and raises game
//  over when HP reaches 0. Sits between the collision/pickup logic and the
//  HP display and game-state logic.
// PARAMETERS
//  HP_INIT     9           HP value after reset or restart
//  HP_MAX      9           heal saturation ceiling (HP_INIT <= HP_MAX <= 15)
//  INVULN_CYC  50_000_000  invulnerability length in clk cycles (>= 1)
//  HIT_PIX     4'h5        current_pix code that means player-hit
// PORTS
//  clk          in   1  system clock
//  rst          in   1  reset, asynchronous, active-low
//  current_pix  in   4  pixel class under the player sprite
//  hazard_req   in   1  damage request, level, held until hazard_ack
//  hazard_ack   out  1  one-cycle pulse: hazard request consumed
//  heal_req     in   1  heal request, level, held until heal_ack
//  heal_ack     out  1  one-cycle pulse: heal request consumed
//  restart      in   1  one-cycle pulse: start a new game
//  hp_numb      out  4  current HP, registered
//  invuln       out  1  high while the invulnerability window runs
//  game_over    out  1  high while HP == 0
// BEHAVIOUR
//  Reset (rst=0, async): hp_numb=HP_INIT, invuln=0, game_over=0, all acks 0,
//   state=IDLE, timer=0, pix_pend=0, rr=PIX.
//  All outputs registered. An event sampled at edge n takes effect after
//   edge n: hp_numb, ack and state change together. Latency is 1 cycle.
//  pix_hit = (current_pix==HIT_PIX) && (prev_pix!=HIT_PIX). This is a
//   rising-edge detect with prev_pix registered. It sets pix_pend.
//   pix_pend clears when it is granted or discarded.
//  Handshake: the ack pulses for exactly 1 cycle. The requester drops req on
//   the cycle it sees the ack. A req that is still high during its own ack
//   cycle is ignored for that cycle.
//  States:
//   IDLE:
//    - Damage pending (pix_pend or hazard_req): grant one damage source.
//      If both are pending, round-robin: rr selects, then rr flips to the
//      other source. The ungranted source stays pending.
//      hp_numb <= hp_numb-1.
//      If the new HP is 0: go to OVER and set game_over=1.
//      Otherwise: go to INVULN, invuln=1, timer=0.
//    - Else if heal_req: heal_ack=1, hp_numb <= min(hp_numb+1, HP_MAX).
//    - Damage always beats heal in the same cycle. The heal waits.
//   INVULN:
//    - timer increments each cycle. When timer==INVULN_CYC-1, go to IDLE,
//      invuln=0, timer=0.
//    - hazard_req is acked and discarded (no HP change).
//    - pix_hit does not set pix_pend, and pix_pend is cleared on entry.
//    - heal_req is granted as in IDLE. The state stays INVULN.
//   OVER:
//    - hp_numb=0, game_over=1.
//    - hazard_req and heal_req are acked and discarded.
//    - pix_pend is held at 0.
//  restart, in any state, has priority over every event:
//   hp_numb=HP_INIT, state=IDLE, invuln=0, game_over=0, timer=0,
//   pix_pend=0, rr=PIX. No ack is issued that cycle.
//  Arithmetic: 4-bit HP.
//   - Decrement from 1 yields 0 and enters OVER. It never wraps.
//   - Increment saturates at HP_MAX.
//   - timer width is $clog2(INVULN_CYC+1).
//  Async reset assertion mid-window aborts the window and all acks at once.
// TESTING (INVULN_CYC=8 in bench)
//  1. Reset, then current_pix 0->5 for 3 cycles -> exactly one decrement,
//     hp 9->8. invuln high for 8 cycles, then low.
//  2. pix_hit and hazard_req in the same cycle from IDLE -> pix granted
//     (hp 8). hazard dropped in INVULN (ack, hp stays 8). The next
//     simultaneous pair grants hazard (rr).
//  3. heal_req with hp=9 -> ack, hp stays 9. After one hit, heal during
//     INVULN -> hp 8->9 and invuln stays high.
//  4. Nine hazard hits spaced >8 cycles -> hp reaches 0, game_over=1.
//     Further reqs are acked, hp stays 0.
//  5. restart while in OVER, and separately mid-INVULN -> hp=9,
//     invuln=0, game_over=0 next cycle.
//  6. Assert rst low mid-INVULN with hp=5 -> immediate hp=9, invuln=0,
//     acks 0.

Source files
------------

// File: rtl/hp_event_arbiter.sv
// -----------------------------------------------------------------------------
// hp_event_arbiter
//   Owns the player HP register. Collects damage from the pixel collision
//   path (rising edge of the player-hit pixel class) and from the hazard
//   logic, plus heal events from pickups. It applies at most one HP update
//   per cycle. After every hit it opens an invulnerability window, and it
//   raises game_over when HP reaches zero.
//
// Ports
//   clk          in   system clock
//   rst          in   asynchronous reset, active-low
//   current_pix  in   [3:0] pixel class under the player sprite
//   hazard_req   in   damage request level, held until hazard_ack
//   hazard_ack   out  one-cycle pulse, hazard request consumed
//   heal_req     in   heal request level, held until heal_ack
//   heal_ack     out  one-cycle pulse, heal request consumed
//   restart      in   one-cycle pulse, start a new game
//   hp_numb      out  [3:0] current HP (registered)
//   invuln       out  high while the invulnerability window runs
//   game_over    out  high while HP == 0
// -----------------------------------------------------------------------------
module hp_event_arbiter #(
  parameter int         HP_INIT    = 9,
  parameter int         HP_MAX     = 9,
  parameter int         INVULN_CYC = 50_000_000,
  parameter logic [3:0] HIT_PIX    = 4'h5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] current_pix,
  input  logic       hazard_req,
  output logic       hazard_ack,
  input  logic       heal_req,
  output logic       heal_ack,
  input  logic       restart,
  output logic [3:0] hp_numb,
  output logic       invuln,
  output logic       game_over
);

  localparam int              TW        = $clog2(INVULN_CYC + 1);
  localparam logic [TW-1:0]   T_LAST    = TW'(INVULN_CYC - 1);
  localparam logic [3:0]      HP_INIT_V = 4'(HP_INIT);
  localparam logic [3:0]      HP_MAX_V  = 4'(HP_MAX);

  typedef enum logic [1:0] {IDLE = 2'd0, INVULN = 2'd1, OVER = 2'd2} state_t;
  typedef enum logic {RR_PIX = 1'b0, RR_HAZ = 1'b1} rr_t;

  state_t        state, state_nx;
  rr_t           rr, rr_nx;
  logic [TW-1:0] timer, timer_nx;
  logic [3:0]    prev_pix;
  logic          pix_pend, pix_pend_nx;
  logic [3:0]    hp_nx;

  logic          pix_hit, pix_eff, haz_eff, heal_eff;
  logic          dmg_grant, take_pix;
  logic          haz_ack_nx, heal_ack_nx;

  // Heal saturates at the ceiling.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= HP_MAX_V) ? HP_MAX_V : v + 4'd1;
  endfunction

  // Damage floors at zero and never wraps.
  function automatic logic [3:0] sat_dec(input logic [3:0] v);
    return (v == 4'd0) ? 4'd0 : v - 4'd1;
  endfunction

  // A request that is still high during its own ack cycle is stale, so the
  // registered ack masks it for that cycle.
  always_comb begin
    pix_hit  = (current_pix == HIT_PIX) && (prev_pix != HIT_PIX);
    pix_eff  = pix_pend || pix_hit;
    haz_eff  = hazard_req && !hazard_ack;
    heal_eff = heal_req && !heal_ack;
  end

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // ---------------- arbitration / next state ----------------
  always_comb begin
    state_nx    = state;
    dmg_grant   = 1'b0;
    take_pix    = 1'b0;
    haz_ack_nx  = 1'b0;
    heal_ack_nx = 1'b0;
    if (restart) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (pix_eff || haz_eff) begin
            dmg_grant  = 1'b1;
            // Pixel wins when it is alone or when it holds the rr token.
            take_pix   = pix_eff && (!haz_eff || rr == RR_PIX);
            haz_ack_nx = !take_pix;
            state_nx   = (hp_numb <= 4'd1) ? OVER : INVULN;
          end else if (heal_eff) begin
            heal_ack_nx = 1'b1;
          end
        end
        INVULN: begin
          haz_ack_nx  = haz_eff;
          heal_ack_nx = heal_eff;
          if (timer == T_LAST) state_nx = IDLE;
        end
        OVER: begin
          haz_ack_nx  = haz_eff;
          heal_ack_nx = heal_eff;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // ---------------- datapath next values ----------------
  always_comb begin
    hp_nx       = hp_numb;
    timer_nx    = '0;
    rr_nx       = rr;
    pix_pend_nx = 1'b0;
    if (restart) begin
      hp_nx = HP_INIT_V;
      rr_nx = RR_PIX;
    end else begin
      case (state)
        IDLE: begin
          if (dmg_grant) begin
            hp_nx = sat_dec(hp_numb);
            if (pix_eff && haz_eff) rr_nx = (rr == RR_PIX) ? RR_HAZ : RR_PIX;
          end else if (heal_ack_nx) begin
            hp_nx = sat_inc(hp_numb);
          end
          // Any grant leaves IDLE, and the pending flag is cleared on entry to
          // INVULN/OVER, so an ungranted pixel hit only survives without a grant.
          pix_pend_nx = pix_eff && !dmg_grant;
        end
        INVULN: begin
          timer_nx = (timer == T_LAST) ? '0 : timer + 1'b1;
          if (heal_ack_nx) hp_nx = sat_inc(hp_numb);
        end
        OVER: hp_nx = 4'd0;
        default: hp_nx = hp_numb;
      endcase
    end
  end

  // ---------------- registered outputs ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hp_numb    <= HP_INIT_V;
      invuln     <= 1'b0;
      game_over  <= 1'b0;
      hazard_ack <= 1'b0;
      heal_ack   <= 1'b0;
      timer      <= '0;
      pix_pend   <= 1'b0;
      rr         <= RR_PIX;
      prev_pix   <= 4'd0;
    end else begin
      hp_numb    <= hp_nx;
      invuln     <= (state_nx == INVULN);
      game_over  <= (state_nx == OVER);
      hazard_ack <= haz_ack_nx;
      heal_ack   <= heal_ack_nx;
      timer      <= timer_nx;
      pix_pend   <= pix_pend_nx;
      rr         <= rr_nx;
      prev_pix   <= current_pix;
    end
  end

endmodule
